// File: rtl/aes_round_sequencer.sv
// Control FSM for the word-serial AES datapath: steps AddRoundKey, SubBytes,
// ShiftRows and MixColumns through the cipher schedule, one column per beat.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       stall,
  input  logic       key_valid,
  output logic       key_req,
  output logic       ark_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic       mix_en,
  output logic [3:0] round,
  output logic [1:0] word_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARK,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] round_nxt;
  logic [1:0] word_nxt;
  logic       last_word;
  logic       final_round;

  assign last_word   = (word_idx == 2'd3);
  assign final_round = (round == LAST_ROUND);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      round    <= '0;
      word_idx <= '0;
    end else begin
      state    <= state_nxt;
      round    <= round_nxt;
      word_idx <= word_nxt;
    end
  end

  // NOTE: every combinational output is given a default before the case
  // statement, so no path through the block can infer a latch.
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    word_nxt  = word_idx;
    if (abort) begin
      state_nxt = S_IDLE;
      round_nxt = '0;
      word_nxt  = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_ARK;
            round_nxt = '0;
            word_nxt  = '0;
          end
        end
        S_ARK: begin
          if (key_valid && !stall) begin
            word_nxt = word_idx + 2'd1;
            if (last_word) begin
              if (final_round) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_SUB;
                round_nxt = round + 4'd1;
              end
            end
          end
        end
        S_SUB: begin
          if (!stall) begin
            word_nxt = word_idx + 2'd1;
            if (last_word) state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The final round skips MixColumns and goes straight to the key add.
          if (!stall) state_nxt = final_round ? S_ARK : S_MIX;
        end
        S_MIX: begin
          if (!stall) begin
            word_nxt = word_idx + 2'd1;
            if (last_word) state_nxt = S_ARK;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          round_nxt = '0;
          word_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_req  = 1'b0;
    ark_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    mix_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_ARK: begin
        busy    = 1'b1;
        key_req = !stall;
        ark_en  = key_valid && !stall;
      end
      S_SUB: begin
        busy   = 1'b1;
        sub_en = !stall;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = !stall;
      end
      S_MIX: begin
        busy   = 1'b1;
        mix_en = !stall;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: a beat-list model of the cipher schedule is stepped in
// lock-step with the sequencer and compared on every cycle.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       stall;
  logic       key_valid;
  logic       key_req;
  logic       ark_en;
  logic       sub_en;
  logic       shift_en;
  logic       mix_en;
  logic [3:0] round;
  logic [1:0] word_idx;
  logic       busy;
  logic       done;

  aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .stall     (stall),
    .key_valid (key_valid),
    .key_req   (key_req),
    .ark_en    (ark_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .mix_en    (mix_en),
    .round     (round),
    .word_idx  (word_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // The whole cipher is a flat list of beats; the model just walks it.
  typedef enum int {K_ARK, K_SUB, K_SHIFT, K_MIX} kind_e;
  typedef struct {
    kind_e kind;
    int    rnd;
    int    wrd;
  } beat_t;
  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_e;

  beat_t sched[$];
  mode_e m_mode;
  int    m_pos;
  int    m_held_r;
  int    m_held_w;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [4:0] s_en;
  logic [3:0] s_round;
  logic [1:0] s_word;
  logic       s_busy;
  logic       s_done;

  logic [3:0] en_log [0:400];
  int         rnd_log[0:400];
  int         cnt_ark, cnt_sub, cnt_shift, cnt_mix;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void build_schedule();
    sched.delete();
    for (int w = 0; w < 4; w++) sched.push_back('{kind: K_ARK, rnd: 0, wrd: w});
    for (int r = 1; r <= NR; r++) begin
      for (int w = 0; w < 4; w++) sched.push_back('{kind: K_SUB, rnd: r, wrd: w});
      sched.push_back('{kind: K_SHIFT, rnd: r, wrd: 0});
      if (r < NR)
        for (int w = 0; w < 4; w++) sched.push_back('{kind: K_MIX, rnd: r, wrd: w});
      for (int w = 0; w < 4; w++) sched.push_back('{kind: K_ARK, rnd: r, wrd: w});
    end
  endfunction

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_pos    = 0;
    m_held_r = 0;
    m_held_w = 0;
  endfunction

  function automatic logic run_at(input kind_e k, input int r, input int w);
    if (m_mode != M_RUN) return 1'b0;
    return sched[m_pos].kind == k && (r < 0 || sched[m_pos].rnd == r) && sched[m_pos].wrd == w;
  endfunction

  // One clock: drive at the falling edge, compare, then advance the model to
  // what the following rising edge must produce.
  task automatic cycle(input logic s, input logic a, input logic st, input logic kv);
    logic [4:0] exp_en;
    int         exp_r, exp_w;
    logic       exp_busy, exp_done, beat;
    beat_t      e;
    @(negedge clk);
    start = s; abort = a; stall = st; key_valid = kv;
    #1;
    cyc++;
    exp_en = '0; exp_r = m_held_r; exp_w = m_held_w;
    exp_busy = 1'b0; exp_done = (m_mode == M_DONE);
    beat = 1'b0;
    if (m_mode == M_RUN) begin
      e = sched[m_pos];
      exp_r = e.rnd; exp_w = e.wrd; exp_busy = 1'b1;
      if (!st) begin
        case (e.kind)
          K_ARK:   exp_en = {kv, 3'b000, 1'b1};
          K_SUB:   exp_en = 5'b01000;
          K_SHIFT: exp_en = 5'b00100;
          default: exp_en = 5'b00010;
        endcase
        beat = (e.kind != K_ARK) || kv;
      end
    end
    s_en    = {ark_en, sub_en, shift_en, mix_en, key_req};
    s_round = round;
    s_word  = word_idx;
    s_busy  = busy;
    s_done  = done;
    check("enables{ark,sub,shift,mix,key_req}", int'(s_en), int'(exp_en));
    check("round", int'(s_round), exp_r);
    check("word_idx", int'(s_word), exp_w);
    check("busy", int'(s_busy), int'(exp_busy));
    check("done", int'(s_done), int'(exp_done));
    if (a) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_RUN; m_pos = 0; end
        M_RUN: if (beat) begin
          m_pos++;
          if (m_pos == sched.size()) begin
            m_mode = M_DONE; m_held_r = NR; m_held_w = 0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // test: 0 nominal, 1 key_valid gap at round 3 word 2, 2 stall in MIX word 1.
  task automatic run_block(input int test, output int done_rc);
    int   drops, stalls;
    logic kv, st;
    drops = 0; stalls = 0; done_rc = -1;
    cnt_ark = 0; cnt_sub = 0; cnt_shift = 0; cnt_mix = 0;
    for (int i = 0; i <= 400; i++) begin en_log[i] = '0; rnd_log[i] = -1; end
    cycle(1'b1, 1'b0, test == 2, 1'b1);
    for (int rc = 1; rc <= 400 && done_rc < 0; rc++) begin
      kv = 1'b1; st = 1'b0;
      if (test == 1 && run_at(K_ARK, 3, 2) && drops < 3) begin kv = 1'b0; drops++; end
      if (test == 2 && run_at(K_MIX, -1, 1) && stalls < 5) begin st = 1'b1; stalls++; end
      cycle(1'b0, 1'b0, st, kv);
      en_log[rc]  = s_en[4:1];
      rnd_log[rc] = int'(s_round);
      cnt_ark   += int'(s_en[4]);
      cnt_sub   += int'(s_en[3]);
      cnt_shift += int'(s_en[2]);
      cnt_mix   += int'(s_en[1]);
      if (s_done) done_rc = rc;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ark_beats"}, cnt_ark, 44);
    check({tag, "_sub_beats"}, cnt_sub, 40);
    check({tag, "_shift_beats"}, cnt_shift, 10);
    check({tag, "_mix_beats"}, cnt_mix, 36);
  endtask

  initial begin
    int done_rc, dones, mix_r10;
    int done_q[$];
    logic aborted;

    build_schedule();
    model_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; key_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("por_outputs", int'({key_req, ark_en, sub_en, shift_en, mix_en, busy, done}), 0);
    check("por_round", int'(round), 0);
    check("por_word_idx", int'(word_idx), 0);
    rst_n = 1'b1;

    // Nominal run.
    run_block(0, done_rc);
    check("nom_done_cycle", done_rc, 131);
    check_counts("nom");
    check("nom_c1_ark", int'(en_log[1]), 4'b1000);
    check("nom_c4_round", rnd_log[4], 0);
    check("nom_c5_sub", int'(en_log[5]), 4'b0100);
    check("nom_c9_shift", int'(en_log[9]), 4'b0010);
    check("nom_c10_mix", int'(en_log[10]), 4'b0001);
    check("nom_c13_mix", int'(en_log[13]), 4'b0001);
    check("nom_c14_ark", int'(en_log[14]), 4'b1000);
    check("nom_c14_round", rnd_log[14], 1);
    check("nom_c122_sub", int'(en_log[122]), 4'b0100);
    check("nom_c122_round", rnd_log[122], 10);
    check("nom_c126_shift", int'(en_log[126]), 4'b0010);
    check("nom_c127_ark", int'(en_log[127]), 4'b1000);
    check("nom_c130_ark", int'(en_log[130]), 4'b1000);
    mix_r10 = 0;
    for (int i = 1; i <= 131; i++) if (rnd_log[i] == 10 && en_log[i][0]) mix_r10++;
    check("nom_mix_in_round10", mix_r10, 0);

    // Round-key word late by three cycles.
    run_block(1, done_rc);
    check("keygap_done_cycle", done_rc, 134);
    check_counts("keygap");

    // Back-pressure in MIX; the start cycle is also stalled (ignored in IDLE).
    run_block(2, done_rc);
    check("stall_done_cycle", done_rc, 136);
    check_counts("stall");

    // Abort in round 5 ShiftRows, then a fresh nominal run.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    aborted = 1'b0; dones = 0;
    for (int rc = 1; rc <= 400 && !aborted; rc++) begin
      if (run_at(K_SHIFT, 5, 0)) begin cycle(1'b0, 1'b1, 1'b0, 1'b1); aborted = 1'b1; end
      else cycle(1'b0, 1'b0, 1'b0, 1'b1);
      dones += int'(s_done);
    end
    check("abort_reached", int'(aborted), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_busy_after", int'(s_busy), 0);
    check("abort_round_cleared", int'(s_round), 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      dones += int'(s_done);
    end
    check("abort_no_done", dones, 0);
    run_block(0, done_rc);
    check("post_abort_done_cycle", done_rc, 131);
    check_counts("post_abort");

    // Start held high across DONE: back-to-back runs, one done each.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 400; i++) en_log[i] = '0;
    for (int rc = 1; rc <= 270; rc++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      en_log[rc] = s_en[4:1];
      if (s_done) done_q.push_back(rc);
    end
    check("held_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("held_done1_cycle", done_q[0], 131);
      check("held_done2_cycle", done_q[1], 263);
    end
    check("held_c132_idle", int'(en_log[132]), 0);
    check("held_c133_ark", int'(en_log[133]), 4'b1000);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of ARK, then power-up-equivalent run.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_ark", int'(s_en[4]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", int'({key_req, ark_en, sub_en, shift_en, mix_en, busy, done}), 0);
    check("async_rst_round", int'(round), 0);
    check("async_rst_word_idx", int'(word_idx), 0);
    @(posedge clk); #1;
    check("rst_held_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_block(0, done_rc);
    check("post_reset_done_cycle", done_rc, 131);
    check_counts("post_reset");

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(3) == 0, $urandom_range(63) == 0,
            $urandom_range(4) == 0, $urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the word-serial (32-bit) AES-128 datapath.
- Steps the AddRoundKey, SubBytes, ShiftRows and MixColumns units through the full cipher schedule: initial key add, NUM_ROUNDS-1 full rounds, then a final round without MixColumns.
- Issues one per-cycle enable plus a column index (word_idx) to the shared 32-bit datapath.
- Handshakes round-key words from the key-expansion block.
- Sits between the top-level cipher interface and the datapath units.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Legal values are 10, 12 and 14; the 12 and 14 values are reserved for AES-192/256 reuse.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one block encryption; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without done.
- stall  in  1  datapath back-pressure; freezes the sequencer.
- key_valid  in  1  key-expansion word available for the current (round, word_idx).
- key_req  out  1  sequencer is waiting on a round-key word.
- ark_en  out  1  AddRoundKey beat on column word_idx.
- sub_en  out  1  SubBytes beat on column word_idx.
- shift_en  out  1  ShiftRows beat, whole state, single cycle.
- mix_en  out  1  MixColumns beat on column word_idx.
- round  out  4  current round, 0..NUM_ROUNDS.
- word_idx  out  2  current column, 0..3.
- busy  out  1  high in any active state.
- done  out  1  one-cycle completion pulse.

Behaviour:
- FSM states: IDLE, ARK, SUB, SHIFT, MIX, DONE.
- Reset (rst_n=0, async): state=IDLE, round=0, word_idx=0. All outputs are 0.
- IDLE: when start=1 at a clock edge, go to ARK with round=0 and word_idx=0. start is ignored in every other state.
- A beat is one cycle in which a datapath enable is high. Enables are combinational from state and handshake inputs.
  - ARK: key_req=~stall. Beat when key_valid & ~stall; ark_en is high only in that cycle. No beat when key_valid=0, and ark_en stays 0.
  - SUB and MIX: beat every cycle when ~stall.
  - SHIFT: one beat when ~stall.
- word_idx increments on each ARK, SUB or MIX beat and wraps 3->0. word_idx is 0 during SHIFT.
- Transitions after the word_idx=3 beat:
  - ARK with round<NUM_ROUNDS: round+1, go to SUB.
  - ARK with round=NUM_ROUNDS: go to DONE.
  - SUB: go to SHIFT.
- After the SHIFT beat:
  - round<NUM_ROUNDS: go to MIX.
  - round=NUM_ROUNDS: go to ARK, so MixColumns is skipped in the final round.
- MIX, after the word_idx=3 beat: go to ARK.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. round and word_idx are held until the next start, and are cleared to 0 when start is accepted.
- busy=1 in ARK, SUB, SHIFT and MIX.
- stall=1: all enables and key_req are 0. State, round and word_idx hold. stall has no effect in IDLE or DONE.
- abort=1 in any state: next state is IDLE with round=0 and word_idx=0, and done is not pulsed. abort has priority over stall and start.
- Exactly one of ark_en, sub_en, shift_en, mix_en may be high in any cycle.
- Nominal latency with stall=0 and key_valid=1, NUM_ROUNDS=10, start sampled at edge 0:
  - beats occupy cycles 1..130, and done=1 in cycle 131.
  - Beat totals: ark 44, sub 40, shift 10, mix 36.
- Latency formula: 4 + 13*(NUM_ROUNDS-1) + 9 active cycles, plus one cycle for each stalled cycle or ARK cycle with key_valid=0.

Test Plan:
- Reset mid-ARK (rst_n pulsed low asynchronously) -> all outputs 0 immediately, FSM in IDLE; a later start behaves exactly as from power-up.
- Nominal run (stall=0, key_valid=1, start one cycle) -> ark_en in cycles 1-4 (round 0), sub_en in 5-8, shift_en in 9, mix_en in 10-13, ark_en in 14-17 (round 1); final round 10: sub 122-125, shift 126, ark 127-130, mix_en never high in round 10; done=1 in cycle 131 only; counts 44/40/10/36.
- key_valid held 0 for 3 cycles at round 3, word_idx=2 -> key_req=1 and ark_en=0 for those cycles, word_idx holds at 2; done arrives at cycle 134.
- stall=1 for 5 cycles during MIX at word_idx=1 -> no enables, round and word_idx frozen; done arrives at cycle 136; stall in IDLE has no effect.
- abort pulsed in round 5 SHIFT -> next cycle IDLE with busy=0 and done never pulsed; a subsequent start gives a full nominal 130-beat run.
- start held high continuously across DONE -> second run begins the cycle after the IDLE re-entry; start pulses while busy are ignored, with one done per run.
